fetch_prefetch_queue: RTL and testbench

Parametrised instruction fetch unit that replaces the single-register fetch path with a prefetching front end. It issues sequential word reads to instruction memory and buffers {pc, instruction} pairs in a DEPTH-entry queue. It presents them to decode through a valid/ready handshake. Redirects from branch, jal and jalr flush the queue and restart fetching. It sits between instruction memory and the decode stage and decouples decode stalls from memory wait states.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue_fifo.sv | 56 +++++
 rtl/fetch_prefetch_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the prefetching instruction fetch front end.
//   NOP_INSTR     : instruction presented to decode when the queue is empty
//   fetch_entry_t : {pc, instr} pair as held in the prefetch queue (32-bit view)
//   fetch_state_t : memory-side request FSM states
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO holding prefetched {pc, instr} entries.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push, wdata  : enqueue (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   flush        : drop all entries; overrides push and pop
//   rdata        : head entry (registered storage, no bypass)
//   count        : entries held; empty / full status
module fetch_queue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign count   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (count == (IDX_W + 1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rptr_q[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetching instruction fetch unit: issues sequential word reads (one outstanding),
// buffers {pc, instr} pairs in a DEPTH-entry queue and hands them to decode via
// valid/ready. A redirect flushes the queue and restarts fetch at redirect_pc.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   imem_request/we_re/mask/addr : read request to instruction memory
//   imem_valid, imem_rdata       : response completing the outstanding request
//   redirect_valid, redirect_pc  : control-flow change from execute
//   if_valid, if_ready           : decode handshake on the queue head
//   if_instr, if_pc              : head entry (NOP / 0 when empty)
//   occupancy                    : entries currently queued
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_request,
  output logic                   imem_we_re,
  output logic [3:0]             imem_mask,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [OCC_W-1:0] DEPTH_CNT = OCC_W'(DEPTH);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  drop_q, drop_d;
  logic                  push, pop, flush;
  logic                  empty, full;
  logic [ENT_W-1:0]      head;

  fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({imem_addr, imem_rdata}),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .count (occupancy),
    .empty (empty),
    .full  (full)
  );

  assign imem_request = (state_q == WAIT);
  assign imem_addr    = addr_q;
  assign imem_we_re   = 1'b0;
  assign imem_mask    = 4'b1111;

  assign if_valid = !empty;
  assign if_pc    = empty ? '0 : head[ENT_W-1 -: ADDR_WIDTH];
  assign if_instr = empty ? INSTR_WIDTH'(NOP_INSTR) : head[INSTR_WIDTH-1:0];

  // In WAIT, fetch_pc equals imem_addr unless a redirect retargeted it; it only
  // advances when a kept response completes.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_pc;
      if (state_q == WAIT && !imem_valid) begin
        // Request stays on the bus; its response must be thrown away.
        drop_d = 1'b1;
      end else begin
        // Queue is flushed, so there is always room to start the new stream.
        state_d = WAIT;
        addr_d  = redirect_pc;
        drop_d  = 1'b0;
      end
    end else begin
      pop = if_valid && if_ready;
      unique case (state_q)
        IDLE: begin
          if (occupancy < DEPTH_CNT) begin
            state_d = WAIT;
            addr_d  = fetch_pc_q;
          end
        end
        WAIT: begin
          if (imem_valid) begin
            if (drop_q) begin
              drop_d = 1'b0;
              if (occupancy < DEPTH_CNT) begin
                addr_d = fetch_pc_q;
              end else begin
                state_d = IDLE;
              end
            end else begin
              push       = 1'b1;
              fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
              // Space check counts the entry being pushed this cycle.
              if ((occupancy + OCC_W'(1)) < DEPTH_CNT) begin
                addr_d = fetch_pc_q + ADDR_WIDTH'(4);
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_request, imem_we_re, imem_valid;
  logic [3:0]  imem_mask;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr, if_pc;
  logic [2:0]  occupancy;

  logic [3:0]  mem_lat = '0;
  logic [3:0]  wcnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_prefetch_queue u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_request   (imem_request),
    .imem_we_re     (imem_we_re),
    .imem_mask      (imem_mask),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .occupancy      (occupancy)
  );

  // Memory model: word at address a reads as 0x1000_0000 + a, answered after mem_lat waits.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign imem_rdata = instr_of(imem_addr);
  assign imem_valid = imem_request && (wcnt >= mem_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt <= '0;
    else if (!imem_request || imem_valid) wcnt <= '0;
    else wcnt <= wcnt + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  occ;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic q, input logic [31:0] a,
                              input logic v, input logic [31:0] p, input logic [2:0] o);
    vec_t t;
    t.rst = r; t.rdy = rd; t.req = q; t.addr = a; t.vld = v; t.pc = p; t.occ = o;
    return t;
  endfunction

  vec_t vecs[22];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found;
    logic        seen_req, seen_vld;
    logic        prev_req, prev_resp;
    logic [31:0] prev_addr, exp_pc, drop_addr;
    int          npops;

    // Sequential fetch with zero-wait memory, then decode stall from reset.
    vecs[0]  = mk(1, 1, 0, 32'h00, 0, 32'h00, 0);
    vecs[1]  = mk(0, 1, 0, 32'h00, 0, 32'h00, 0);
    vecs[2]  = mk(0, 1, 1, 32'h00, 0, 32'h00, 0);
    vecs[3]  = mk(0, 1, 1, 32'h04, 1, 32'h00, 1);
    vecs[4]  = mk(0, 1, 1, 32'h08, 1, 32'h04, 1);
    vecs[5]  = mk(0, 1, 1, 32'h0C, 1, 32'h08, 1);
    vecs[6]  = mk(1, 0, 0, 32'h00, 0, 32'h00, 0);
    vecs[7]  = mk(0, 0, 0, 32'h00, 0, 32'h00, 0);
    vecs[8]  = mk(0, 0, 1, 32'h00, 0, 32'h00, 0);
    vecs[9]  = mk(0, 0, 1, 32'h04, 1, 32'h00, 1);
    vecs[10] = mk(0, 0, 1, 32'h08, 1, 32'h00, 2);
    vecs[11] = mk(0, 0, 1, 32'h0C, 1, 32'h00, 3);
    for (int i = 12; i <= 16; i++) vecs[i] = mk(0, 0, 0, 32'h0C, 1, 32'h00, 4);
    vecs[17] = mk(0, 1, 0, 32'h0C, 1, 32'h00, 4);
    vecs[18] = mk(0, 1, 0, 32'h0C, 1, 32'h04, 3);
    vecs[19] = mk(0, 1, 1, 32'h10, 1, 32'h08, 2);
    vecs[20] = mk(0, 1, 1, 32'h14, 1, 32'h0C, 2);
    vecs[21] = mk(0, 1, 1, 32'h18, 1, 32'h10, 2);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      if_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_req", i), imem_request, vecs[i].req);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), if_valid, vecs[i].vld);
      chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].pc);
      chk($sformatf("vec%0d_occ", i), occupancy, vecs[i].occ);
      chk($sformatf("vec%0d_instr", i), if_instr,
          vecs[i].vld ? instr_of(vecs[i].pc) : 32'h0000_0013);
    end
    chk("tie_we_re", imem_we_re, 0);
    chk("tie_mask", imem_mask, 4'hF);

    // Wait-state memory: address stable during wait, one in-order entry per response.
    mem_lat  = 4'd3;
    if_ready = 1'b1;
    do_reset();
    prev_req = 0; prev_resp = 0; prev_addr = '0; exp_pc = '0; npops = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (imem_request && prev_req && !prev_resp) chk("wait_addr_stable", imem_addr, prev_addr);
      if (if_valid && if_ready) begin
        chk("wait_pc_order", if_pc, exp_pc);
        chk("wait_instr", if_instr, instr_of(exp_pc));
        exp_pc += 32'd4;
        npops++;
      end
      prev_req  = imem_request;
      prev_addr = imem_addr;
      prev_resp = imem_valid;
    end
    chk("wait_pop_count_ge8", npops >= 8, 1);

    // Redirect while the 0x8 request is outstanding; its response arrives 2 cycles later.
    mem_lat = 4'd2;
    do_reset();
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      #1;
      if (imem_request && imem_addr == 32'h8 && wcnt == 4'd0) found = 1;
    end
    chk("redir_found_req8", found, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("redir_flush_valid", if_valid, 0);
    chk("redir_hold_req", imem_request, 1);
    chk("redir_hold_addr", imem_addr, 32'h8);
    seen_req = 0; seen_vld = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (if_valid) chk("redir_no_stale_instr", if_instr == instr_of(32'h8), 0);
      if (imem_request && imem_addr != 32'h8 && !seen_req) begin
        chk("redir_next_req", imem_addr, 32'h100);
        seen_req = 1;
      end
      if (if_valid && !seen_vld) begin
        chk("redir_first_pc", if_pc, 32'h100);
        seen_vld = 1;
      end
    end
    chk("redir_saw_req", seen_req, 1);
    chk("redir_saw_valid", seen_vld, 1);

    // Redirect, response and pop all in one cycle.
    mem_lat = 4'd0;
    do_reset();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      #1;
      if (if_valid && imem_valid) found = 1;
    end
    chk("coinc_found", found, 1);
    drop_addr      = imem_addr;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("coinc_occ0", occupancy, 0);
    chk("coinc_valid0", if_valid, 0);
    chk("coinc_req_addr", imem_addr, 32'h200);
    @(negedge clk);
    #1;
    chk("coinc_valid1", if_valid, 1);
    chk("coinc_pc", if_pc, 32'h200);
    chk("coinc_dropped", if_pc == drop_addr, 0);

    // Asynchronous reset while three entries are queued and a request is pending.
    mem_lat  = 4'd2;
    if_ready = 1'b0;
    do_reset();
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      #1;
      if (occupancy == 3'd3 && imem_request) found = 1;
    end
    chk("rstmid_found", found, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_req", imem_request, 0);
    chk("rstmid_addr", imem_addr, 32'h0);
    chk("rstmid_valid", if_valid, 0);
    chk("rstmid_occ", occupancy, 0);
    chk("rstmid_pc", if_pc, 32'h0);
    chk("rstmid_instr", if_instr, 32'h0000_0013);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_c0_req", imem_request, 0);
    @(negedge clk);
    #1;
    chk("rstmid_c1_req", imem_request, 1);
    chk("rstmid_c1_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
